// File: rtl/fp_pkg.sv
// Shared fixed-point package: default format, saturation limits,
// ALU op encodings and the divider state encoding.
package fp_pkg;

    localparam int FP_N    = 32;
    localparam int FP_FRAC = FP_N / 2;

    // Saturation limits for the default word width.
    localparam logic [FP_N-1:0] FP_MAX = {1'b0, {(FP_N-1){1'b1}}};
    localparam logic [FP_N-1:0] FP_MIN = {1'b1, {(FP_N-1){1'b0}}};

    // Saturation limits for any width up to 64 bits; callers slice [n-1:0].
    function automatic logic [63:0] fp_max_of(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fp_min_of(input int n);
        return 64'd1 << (n - 1);
    endfunction

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fp_div_seq_if #(parameter int N = 32);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero, overflow
    );

endinterface

// File: rtl/fp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module fp_div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] divisor,
    input  logic         dbit,
    output logic [N:0]   rem_next,
    output logic         qbit
);

    logic [N+1:0] shifted;
    logic [N+1:0] diff;

    // The remainder is always below the divisor, so one extra bit of
    // headroom on the shifted value is enough to avoid losing the MSB.
    always_comb begin
        shifted  = {rem, dbit};
        diff     = shifted - {2'b00, divisor};
        qbit     = (shifted >= {2'b00, divisor});
        rem_next = qbit ? diff[N:0] : shifted[N:0];
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider: (a << FRAC) / b, one quotient
// bit per clock, truncating toward zero and saturating on overflow or b == 0.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int N    = FP_N,
    parameter int FRAC = FP_FRAC
) (
    input logic        clk,
    input logic        rst,
    fp_div_seq_if.slave bus
);

    localparam int STEPS = N + FRAC;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [63:0]  SAT_MAX_W = fp_max_of(N);
    localparam logic [63:0]  SAT_MIN_W = fp_min_of(N);
    localparam logic [N-1:0] SAT_MAX = SAT_MAX_W[N-1:0];
    localparam logic [N-1:0] SAT_MIN = SAT_MIN_W[N-1:0];

    div_state_t state, state_next;

    logic             sign;
    logic             b_zero;
    logic [N-1:0]     mag_b;
    logic [STEPS-1:0] dvd;
    logic [STEPS-1:0] quo;
    logic [N:0]       rem;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     res_q;
    logic             dz_q;
    logic             ovf_q;

    logic             accept;
    logic [N-1:0]     mag_a_in;
    logic [N-1:0]     mag_b_in;
    logic [N:0]       rem_next;
    logic             qbit;
    logic [N-1:0]     fix_result;
    logic             fix_ovf;
    logic             q_hi;
    logic [N-1:0]     q_lo;

    assign accept   = bus.in_valid && bus.in_ready;
    // 0x8000... negates to itself, which is exactly its unsigned magnitude.
    assign mag_a_in = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
    assign mag_b_in = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;

    assign bus.in_ready    = (state == IDLE) && !rst;
    assign bus.out_valid   = (state == DONE);
    assign bus.result      = res_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;

    fp_div_step #(.N(N)) u_step (
        .rem      (rem),
        .divisor  (mag_b),
        .dbit     (dvd[STEPS-1]),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: zero divisor skips the iteration and goes straight to FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (bus.b == '0) ? FIX : CALC;
            CALC: if (cnt == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign application and saturation of the STEPS-bit unsigned quotient.
    always_comb begin
        q_hi       = |quo[STEPS-1:N];
        q_lo       = quo[N-1:0];
        fix_result = q_lo;
        fix_ovf    = 1'b0;
        if (b_zero) begin
            fix_result = sign ? SAT_MIN : SAT_MAX;
        end else if (!sign) begin
            if (q_hi || q_lo[N-1]) begin
                fix_result = SAT_MAX;
                fix_ovf    = 1'b1;
            end
        end else begin
            if (q_hi || (q_lo[N-1] && |q_lo[N-2:0])) begin
                fix_result = SAT_MIN;
                fix_ovf    = 1'b1;
            end else begin
                fix_result = ~q_lo + 1'b1;
            end
        end
    end

    // Operand capture, restoring iteration and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign   <= 1'b0;
            b_zero <= 1'b0;
            mag_b  <= '0;
            dvd    <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            res_q  <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // With b == 0 the sign reduces to a's sign, which picks the rail.
                    sign   <= bus.a[N-1] ^ bus.b[N-1];
                    b_zero <= (bus.b == '0);
                    mag_b  <= mag_b_in;
                    dvd    <= {mag_a_in, {FRAC{1'b0}}};
                    quo    <= '0;
                    rem    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= {quo[STEPS-2:0], qbit};
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    res_q <= fix_result;
                    dz_q  <= b_zero;
                    ovf_q <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq: reset, signed division, divide-by-zero,
// saturation boundaries, output backpressure and reset mid-iteration.
module tb_fp_div_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fp_div_seq_if #(.N(32)) bus ();

    fp_div_seq #(.N(32), .FRAC(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operand pair once in_ready is seen; E0 is the edge consumed here.
    task automatic accept_op(input logic [31:0] av, input logic [31:0] bv, output bit ok);
        int waited;
        waited = 0;
        ok     = 1'b0;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.in_ready) begin
            ok           = 1'b1;
            bus.a        = av;
            bus.b        = bv;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Count edges after E0 until out_valid is observed, bounded.
    task automatic wait_valid(output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (bus.out_valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.div_by_zero !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ov=%b res=%h dz=%b ovf=%b ir=%b, need all zero",
                     bus.out_valid, bus.result, bus.div_by_zero, bus.overflow, bus.in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b need 1", bus.in_ready);
        end
    endtask

    task automatic test_divide(input string name, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp_res, input bit exp_dz, input bit exp_ovf,
                               input int exp_lat);
        bit ok;
        bit seen;
        int edges;
        accept_op(av, bv, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_accept: in_ready never high", name);
        end
        wait_valid(edges, seen);
        total++;
        if (!seen || edges != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges (seen=%0b) need %0d", name, edges, seen, exp_lat);
        end
        total++;
        if (bus.result !== exp_res) begin
            bad++;
            $display("FAIL %s_result: got %h need %h", name, bus.result, exp_res);
        end
        total++;
        if (bus.div_by_zero !== exp_dz) begin
            bad++;
            $display("FAIL %s_dz: got %b need %b", name, bus.div_by_zero, exp_dz);
        end
        total++;
        if (bus.overflow !== exp_ovf) begin
            bad++;
            $display("FAIL %s_ovf: got %b need %b", name, bus.overflow, exp_ovf);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handoff: out_valid=%b in_ready=%b need 0/1", name, bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.result !== exp_res) begin
            bad++;
            $display("FAIL %s_hold: got %h need %h", name, bus.result, exp_res);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        int edges;
        accept_op(32'h0003_0000, 32'h0002_0000, ok);
        wait_valid(edges, seen);
        total++;
        if (!ok || !seen || bus.result !== 32'h0001_8000) begin
            bad++;
            $display("FAIL bp_first: ok=%0b seen=%0b res=%h need 00018000", ok, seen, bus.result);
        end
        // A competing operand while the result is parked must be ignored.
        bus.a        = 32'h0005_0000;
        bus.b        = 32'h0000_0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.result !== 32'h0001_8000 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: res=%h ir=%b ov=%b need 00018000/0/1",
                         i, bus.result, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ir=%b ov=%b dz=%b need 1/0/0", bus.in_ready, bus.out_valid, bus.div_by_zero);
        end
        test_divide("bp_next", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        accept_op(32'h0007_0000, 32'h0002_0000, ok);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (!ok || bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.div_by_zero !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: ok=%0b ov=%b res=%h dz=%b ovf=%b ir=%b, need zeros",
                     ok, bus.out_valid, bus.result, bus.div_by_zero, bus.overflow, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release: ir=%b ov=%b need 1/0", bus.in_ready, bus.out_valid);
        end
        test_divide("midrst_next", 32'h0006_0000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0, 1'b0, 49);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_divide("pos",      32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49);
        test_divide("neg_a",    32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 49);
        test_divide("trunc",    32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
        test_divide("neg_both", 32'hFFFF_0000, 32'hFFFD_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
        test_divide("dz_pos",   32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        test_divide("dz_neg",   32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
        test_divide("ovf_big",  32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, 1'b1, 49);
        test_divide("ovf_min",  32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 49);
        test_divide("min_fits", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49);
        test_backpressure();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential signed fixed-point divider for the physics datapath's Q(N-FRAC).(FRAC) format, default Q16.16. It computes (a << FRAC) / b one quotient bit per cycle with a restoring algorithm, and saturates on overflow and divide-by-zero. It uses a valid/ready handshake on both input and output, so the physics pipeline can place it alongside `fp_alu`, which handles single-cycle add, subtract and multiply.

## Interface
- `N`, 32, total word width in bits, two's complement.
- `FRAC`, `N/2`, number of fractional bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the operand pair is valid.
- `in_ready`  out  1  high only in IDLE while `rst` is low.
- `a`  in  N  dividend, signed fixed point.
- `b`  in  N  divisor, signed fixed point.
- `out_valid`  out  1  `result` and the flags are valid.
- `out_ready`  in  1  the consumer accepts the result.
- `result`  out  N  signed quotient, truncated toward zero, saturated.
- `div_by_zero`  out  1  set when b == 0.
- `overflow`  out  1  set when the true quotient does not fit in N bits.

## Operation
- **Accept:** an operand pair is accepted on an edge where `in_valid && in_ready`. At that edge the block latches:
  - the sign, s = a[N-1] ^ b[N-1];
  - the unsigned N-bit magnitudes |a| and |b|. 0x80000000 has magnitude 2^31 and is held correctly in an unsigned register.
- **Dividend:** D = |a| << FRAC, which is N+FRAC bits wide. The partial remainder is N+1 bits wide.
- **States:**
  - **IDLE → CALC** on accept when b != 0.
  - **IDLE → FIX** on accept when b == 0.
  - **CALC:** one restoring step per edge, taking D bits MSB-first. Each step shifts the remainder left by one bit plus the next D bit, trial-subtracts |b|, and shifts the quotient bit in. A counter runs N+FRAC steps, then the state moves to FIX.
  - **FIX:** one edge. It applies the sign, checks saturation, and loads `result`, `div_by_zero` and `overflow`. The state then moves to DONE.
  - **DONE:** `out_valid` = 1, and `result` and the flags are held stable. On an edge with `out_ready` high the state moves to IDLE.
- **Saturation rules:** Q is the N+FRAC-bit unsigned quotient.
  - s = 0 and Q > 2^(N-1)-1 → `result` = 0x7FFF_FFFF, `overflow` = 1.
  - s = 1 and Q > 2^(N-1) → `result` = 0x8000_0000, `overflow` = 1.
  - Otherwise `result` = s ? -Q[N-1:0] : Q[N-1:0], `overflow` = 0.
  - b == 0 → `div_by_zero` = 1 and `overflow` = 0. `result` = 0x7FFF_FFFF if a[N-1] = 0 (this includes a == 0), else 0x8000_0000.
- **No pipelining:** there is one operation in flight. Inputs are ignored outside IDLE.

## Timing
- **Reset:** asserting `rst` immediately forces:
  - state = IDLE and the counter = 0;
  - `out_valid` = 0, `result` = 0, `div_by_zero` = 0, `overflow` = 0;
  - `in_ready` = 0 while `rst` is high.
  
  `in_ready` = 1 in the first cycle after `rst` deasserts.
- **Reset mid-operation:** `rst` asserted in CALC, FIX or DONE aborts the operation and behaves exactly as reset above. No result is emitted.
- **Latency, normal case:** accept at edge E0, CALC iterates on E1..E(N+FRAC), and FIX executes at E(N+FRAC+1). `out_valid` is high after that edge, which is E49 for the defaults.
- **Latency, divide-by-zero:** FIX executes at E1, so `out_valid` is high after E1.
- **Output handshake:** the output transfers on the edge where `out_valid && out_ready`. `out_valid` falls and `in_ready` rises in the following cycle. There is no same-cycle accept of a new operand on a transfer edge.
- **Throughput:** with `out_ready` tied high, one operation per N+FRAC+3 cycles (51 for the defaults).
- **After transfer:** `result` and the flags keep their last values after the transfer until the next FIX.

## Structure
- **Shared package `fp_pkg`:**
  - default N and FRAC;
  - FP_MAX (0x7FFF_FFFF) and FP_MIN (0x8000_0000) as width-parameterised constants;
  - the ALU op encodings (ADD/SUB/MUL/DIV), moved there from macros;
  - the divider state enum {IDLE, CALC, FIX, DONE}.
- **Sub-module `fp_div_step`:** a combinational single restoring step. It takes the remainder, |b| and the incoming dividend bit, and returns the next remainder and the quotient bit. The top module instantiates it once and iterates it sequentially.

## Test plan
- **Positive:** a=0x0003_0000 (3.0), b=0x0002_0000 (2.0) → `result` 0x0001_8000, both flags 0, `out_valid` first high 49 edges after accept.
- **Signs:**
  - a=0xFFFD_0000 (-3.0), b=0x0002_0000 → 0xFFFE_8000 (-1.5).
  - a=0x0001_0000, b=0x0003_0000 → 0x0000_5555 (truncated).
  - a=0xFFFF_0000, b=0xFFFD_0000 → 0x0000_5555.
- **Divide-by-zero:**
  - a=0x0005_0000, b=0 → 0x7FFF_FFFF, `div_by_zero`=1, `out_valid` after 1 edge.
  - a=0xFFFB_0000, b=0 → 0x8000_0000.
- **Overflow boundaries:**
  - a=0x7FFF_0000, b=0x0000_0100 → 0x7FFF_FFFF, `overflow`=1.
  - a=0x8000_0000, b=0xFFFF_0000 → 0x7FFF_FFFF, `overflow`=1.
  - a=0x8000_0000, b=0x0001_0000 → 0x8000_0000, `overflow`=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE and drive a new `in_valid` operand meanwhile. Required response: `result` stays stable, `in_ready`=0, and the new operand is ignored. Then release `out_ready`; `in_ready` is 1 the next cycle and the subsequent division is correct.
- **Reset mid-CALC:** assert `rst` at step 20 of CALC. Required response: `out_valid`=0 and all outputs 0 immediately, `in_ready` 1 the first cycle after deassert, and the next operation (6.0 / -2.0) → 0xFFFD_0000.
